// File: rtl/bottle_fill_ctrl.sv
// Bottle-fill sequencer: drives the pill counter controls, holds the BCD
// per-bottle capacity, detects bottle completion and counts filled bottles
// toward the batch target.
module bottle_fill_ctrl #(
   parameter int unsigned BOTTLE_TARGET = 10,
   parameter int unsigned SWAP_CYCLES   = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       start,
   input  logic       pause,
   input  logic       set_mode,
   input  logic       incL,
   input  logic       incH,
   input  logic       ack_full,
   input  logic [3:0] cntL,
   input  logic [3:0] cntH,
   output logic       EN_work,
   output logic       EN_set,
   output logic       set,
   output logic       isWork,
   output logic       conti,
   output logic [3:0] maxL,
   output logic [3:0] maxH,
   output logic [3:0] bottlesL,
   output logic [3:0] bottlesH,
   output logic       allFull,
   output logic       err,
   output logic [2:0] state
);

   localparam int unsigned DW = 4;
   localparam int unsigned SW = 3;
   localparam int unsigned CW = 8;

   // Batch target split into BCD digits for comparison with the bottle count
   localparam logic [DW-1:0] TGT_L     = DW'(BOTTLE_TARGET % 10);
   localparam logic [DW-1:0] TGT_H     = DW'(BOTTLE_TARGET / 10);
   localparam logic [CW-1:0] SWAP_LOAD = CW'(SWAP_CYCLES - 1);

   typedef enum logic [SW-1:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_ARM   = 3'd2,
      S_FILL  = 3'd3,
      S_SWAP  = 3'd4,
      S_HOLD  = 3'd5,
      S_FULL  = 3'd6
   } state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] maxl_q, maxl_d;
   logic [DW-1:0] maxh_q, maxh_d;
   logic [DW-1:0] botl_q, botl_d;
   logic [DW-1:0] both_q, both_d;
   logic [CW-1:0] swap_cnt_q, swap_cnt_d;
   logic          err_q, err_d;
   logic          full_q, full_d;
   logic          pend_q, pend_d;
   logic          conti_q, conti_d;
   logic          en_work_q, en_work_d;
   logic          en_set_q, en_set_d;
   logic          set_q, set_d;
   logic          is_work_q, is_work_d;
   logic          done_c;
   logic [2*DW-1:0] bot_inc_c;

   // Single BCD digit increment, 9 wraps to 0
   function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] d);
      return (d >= 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

   // Two-digit BCD increment saturating at 99
   function automatic logic [2*DW-1:0] bcd_sat_inc(input logic [2*DW-1:0] v);
      logic [2*DW-1:0] r;
      if (v == 8'h99) begin
         r = v;
      end else if (v[DW-1:0] >= 4'd9) begin
         r = {bcd_inc(v[2*DW-1:DW]), 4'd0};
      end else begin
         r = {v[2*DW-1:DW], v[DW-1:0] + 4'd1};
      end
      return r;
   endfunction

   // Next-state, datapath updates and per-state counter controls
   always_comb begin
      state_d    = state_q;
      maxl_d     = maxl_q;
      maxh_d     = maxh_q;
      botl_d     = botl_q;
      both_d     = both_q;
      swap_cnt_d = swap_cnt_q;
      err_d      = err_q;
      full_d     = full_q;
      pend_d     = pend_q;
      conti_d    = 1'b0;
      done_c     = 1'b0;
      bot_inc_c  = bcd_sat_inc({both_q, botl_q});

      case (state_q)
         S_IDLE: begin
            if (set_mode) begin
               state_d = S_SETUP;
            end else if (start) begin
               if (maxl_q == 4'd0 && maxh_q == 4'd0) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_ARM;
                  botl_d  = 4'd0;
                  both_d  = 4'd0;
                  err_d   = 1'b0;
               end
            end
         end
         S_SETUP: begin
            if (incL) maxl_d = bcd_inc(maxl_q);
            if (incH) maxh_d = bcd_inc(maxh_q);
            if (set_mode) state_d = S_IDLE;
         end
         S_ARM: begin
            state_d = S_FILL;
         end
         S_FILL: begin
            done_c = (cntL == maxl_q) && (cntH == maxh_q);
            if (done_c) begin
               // completion beats a coincident pause; the pause is deferred
               state_d    = S_SWAP;
               swap_cnt_d = SWAP_LOAD;
               pend_d     = pause;
               both_d     = bot_inc_c[2*DW-1:DW];
               botl_d     = bot_inc_c[DW-1:0];
            end else if (pause) begin
               state_d = S_HOLD;
            end
         end
         S_SWAP: begin
            if (pause) pend_d = 1'b1;
            if (swap_cnt_q == '0) begin
               if (botl_q == TGT_L && both_q == TGT_H) begin
                  state_d = S_FULL;
                  full_d  = 1'b1;
                  pend_d  = 1'b0;
               end else if (pend_q || pause) begin
                  state_d = S_HOLD;
                  pend_d  = 1'b0;
               end else begin
                  state_d = S_FILL;
                  conti_d = 1'b1;
               end
            end else begin
               swap_cnt_d = swap_cnt_q - 8'd1;
            end
         end
         S_HOLD: begin
            if (start) begin
               state_d = S_FILL;
               conti_d = 1'b1;
            end
         end
         S_FULL: begin
            if (ack_full) begin
               state_d = S_ARM;
               botl_d  = 4'd0;
               both_d  = 4'd0;
               full_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Counter controls follow the state being entered so they align with state
      en_work_d = (state_d == S_IDLE) || (state_d == S_ARM);
      en_set_d  = en_work_d;
      set_d     = ~en_work_d;
      is_work_d = (state_d == S_FILL);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         maxl_q     <= 4'd1;
         maxh_q     <= 4'd0;
         botl_q     <= 4'd0;
         both_q     <= 4'd0;
         swap_cnt_q <= '0;
         err_q      <= 1'b0;
         full_q     <= 1'b0;
         pend_q     <= 1'b0;
         conti_q    <= 1'b0;
         en_work_q  <= 1'b1;
         en_set_q   <= 1'b1;
         set_q      <= 1'b0;
         is_work_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         maxl_q     <= maxl_d;
         maxh_q     <= maxh_d;
         botl_q     <= botl_d;
         both_q     <= both_d;
         swap_cnt_q <= swap_cnt_d;
         err_q      <= err_d;
         full_q     <= full_d;
         pend_q     <= pend_d;
         conti_q    <= conti_d;
         en_work_q  <= en_work_d;
         en_set_q   <= en_set_d;
         set_q      <= set_d;
         is_work_q  <= is_work_d;
      end
   end

   assign EN_work  = en_work_q;
   assign EN_set   = en_set_q;
   assign set      = set_q;
   assign isWork   = is_work_q;
   assign conti    = conti_q;
   assign maxL     = maxl_q;
   assign maxH     = maxh_q;
   assign bottlesL = botl_q;
   assign bottlesH = both_q;
   assign allFull  = full_q;
   assign err      = err_q;
   assign state    = SW'(state_q);

endmodule

// File: tb/tb_bottle_fill_ctrl.sv
// Testbench for bottle_fill_ctrl: vector table, directed multi-cycle
// sequences, and randomized stimulus against a reference model.
module tb_bottle_fill_ctrl;

   localparam int unsigned TGT_A  = 2;
   localparam int unsigned TGT_B  = 10;
   localparam int unsigned SWAP_N = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       start = 1'b0, pause = 1'b0, set_mode = 1'b0;
   logic       incL = 1'b0, incH = 1'b0, ack_full = 1'b0;
   logic [3:0] cntL = 4'd0, cntH = 4'd0;

   logic       a_EN_work, a_EN_set, a_set, a_isWork, a_conti, a_allFull, a_err;
   logic [3:0] a_maxL, a_maxH, a_botL, a_botH;
   logic [2:0] a_state;
   logic       b_EN_work, b_EN_set, b_set, b_isWork, b_conti, b_allFull, b_err;
   logic [3:0] b_maxL, b_maxH, b_botL, b_botH;
   logic [2:0] b_state;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   bottle_fill_ctrl #(.BOTTLE_TARGET(TGT_A), .SWAP_CYCLES(SWAP_N)) u_dut_a (
      .CLK(CLK), .RST(RST), .start(start), .pause(pause), .set_mode(set_mode),
      .incL(incL), .incH(incH), .ack_full(ack_full), .cntL(cntL), .cntH(cntH),
      .EN_work(a_EN_work), .EN_set(a_EN_set), .set(a_set), .isWork(a_isWork),
      .conti(a_conti), .maxL(a_maxL), .maxH(a_maxH), .bottlesL(a_botL),
      .bottlesH(a_botH), .allFull(a_allFull), .err(a_err), .state(a_state));

   bottle_fill_ctrl #(.BOTTLE_TARGET(TGT_B), .SWAP_CYCLES(SWAP_N)) u_dut_b (
      .CLK(CLK), .RST(RST), .start(start), .pause(pause), .set_mode(set_mode),
      .incL(incL), .incH(incH), .ack_full(ack_full), .cntL(cntL), .cntH(cntH),
      .EN_work(b_EN_work), .EN_set(b_EN_set), .set(b_set), .isWork(b_isWork),
      .conti(b_conti), .maxL(b_maxL), .maxH(b_maxH), .bottlesL(b_botL),
      .bottlesH(b_botH), .allFull(b_allFull), .err(b_err), .state(b_state));

   // Reference model of instance A: capacity and bottle count as plain integers
   int m_st, m_maxl, m_maxh, m_bot, m_swap_left;
   bit m_err, m_full, m_conti, m_pend;

   task automatic m_step();
      m_conti = 1'b0;
      if (RST) begin
         m_st = 0; m_maxl = 1; m_maxh = 0; m_bot = 0;
         m_err = 1'b0; m_full = 1'b0; m_pend = 1'b0; m_swap_left = 0;
      end else begin
         case (m_st)
            0: if (set_mode) m_st = 1;
               else if (start) begin
                  if (m_maxl * 10 + m_maxh == 0) m_err = 1'b1;
                  else begin m_st = 2; m_bot = 0; m_err = 1'b0; end
               end
            1: begin
               if (incL) m_maxl = (m_maxl + 1) % 10;
               if (incH) m_maxh = (m_maxh + 1) % 10;
               if (set_mode) m_st = 0;
            end
            2: m_st = 3;
            3: if (int'(cntL) == m_maxl && int'(cntH) == m_maxh) begin
                  m_bot = (m_bot < 99) ? m_bot + 1 : 99;
                  m_st = 4; m_swap_left = SWAP_N;
                  if (pause) m_pend = 1'b1;
               end else if (pause) m_st = 5;
            4: begin
               if (pause) m_pend = 1'b1;
               m_swap_left--;
               if (m_swap_left == 0) begin
                  if (m_bot == TGT_A) begin m_st = 6; m_full = 1'b1; m_pend = 1'b0; end
                  else if (m_pend) begin m_st = 5; m_pend = 1'b0; end
                  else begin m_st = 3; m_conti = 1'b1; end
               end
            end
            5: if (start) begin m_st = 3; m_conti = 1'b1; end
            6: if (ack_full) begin m_st = 2; m_bot = 0; m_full = 1'b0; end
            default: m_st = 0;
         endcase
      end
   endtask

   function automatic logic [31:0] m_vec();
      bit en;
      en = (m_st == 0) || (m_st == 2);
      return 32'({3'(m_st), 4'(m_maxl), 4'(m_maxh), 4'(m_bot % 10), 4'(m_bot / 10),
                  m_full, m_err, m_conti, (m_st == 3), en, en, ~en});
   endfunction

   function automatic logic [31:0] a_vec();
      return 32'({a_state, a_maxL, a_maxH, a_botL, a_botH, a_allFull, a_err,
                  a_conti, a_isWork, a_EN_work, a_EN_set, a_set});
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, advance the model, sample after the edge
   task automatic drive(input logic r, s, p, sm, il, ih, ak, input logic [3:0] cl, ch);
      RST = r; start = s; pause = p; set_mode = sm;
      incL = il; incH = ih; ack_full = ak; cntL = cl; cntH = ch;
      m_step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input logic [3:0] cl, ch);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cl, ch);
   endtask

   // Vector table: inputs and expected state/capacity/err
   typedef struct {
      logic r, s, p, sm, il, ih, ak;
      logic [2:0] st;
      logic [3:0] ml, mh;
      logic       er;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic r, s, p, sm, il, ih, ak,
                      input logic [2:0] st, input int ml, mh, input logic er);
      vec_t v;
      v.r = r; v.s = s; v.p = p; v.sm = sm; v.il = il; v.ih = ih; v.ak = ak;
      v.st = st; v.ml = 4'(ml); v.mh = 4'(mh); v.er = er;
      tbl.push_back(v);
   endtask

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      logic [3:0] cl, ch;

      // capacity programming and IDLE -> ARM -> FILL
      add(1,0,0,0,0,0,0, 0, 1, 0, 0);
      add(0,0,0,1,0,0,0, 1, 1, 0, 0);
      for (int k = 2; k <= 4; k++) add(0,0,0,0,1,0,0, 1, k, 0, 0);
      add(0,0,0,1,0,0,0, 0, 4, 0, 0);
      add(0,1,0,0,0,0,0, 2, 4, 0, 0);
      add(0,0,0,0,0,0,0, 3, 4, 0, 0);
      // capacity 00 refused with sticky err, then 05 accepted
      add(1,0,0,0,0,0,0, 0, 1, 0, 0);
      add(0,0,0,1,0,0,0, 1, 1, 0, 0);
      for (int k = 1; k <= 9; k++) add(0,0,0,0,1,0,0, 1, (1 + k) % 10, 0, 0);
      add(0,0,0,1,0,0,0, 0, 0, 0, 0);
      add(0,1,0,0,0,0,0, 0, 0, 0, 1);
      add(0,0,0,1,0,0,0, 1, 0, 0, 1);
      for (int k = 1; k <= 5; k++) add(0,0,0,0,1,0,0, 1, k, 0, 1);
      add(0,0,0,1,0,0,0, 0, 5, 0, 1);
      add(0,1,0,0,0,0,0, 2, 5, 0, 0);
      // digit wrap without carry, joint increment, start/pause ignored in SETUP
      add(1,0,0,0,0,0,0, 0, 1, 0, 0);
      add(0,0,0,1,0,0,0, 1, 1, 0, 0);
      for (int k = 1; k <= 3; k++) add(0,0,0,0,0,1,0, 1, 1, k, 0);
      for (int k = 1; k <= 10; k++) add(0,0,0,0,1,0,0, 1, (1 + k) % 10, 3, 0);
      add(0,1,1,0,0,0,0, 1, 1, 3, 0);
      for (int k = 2; k <= 9; k++) add(0,0,0,0,1,0,0, 1, k, 3, 0);
      for (int k = 4; k <= 9; k++) add(0,0,0,0,0,1,0, 1, 9, k, 0);
      add(0,0,0,0,1,1,0, 1, 0, 0, 0);
      add(0,0,0,1,0,0,0, 0, 0, 0, 0);

      foreach (tbl[i]) begin
         logic en;
         drive(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].sm, tbl[i].il, tbl[i].ih, tbl[i].ak,
               4'd0, 4'd0);
         en = (tbl[i].st == 3'd0) || (tbl[i].st == 3'd2);
         chk($sformatf("table[%0d] st/max/err/ctl", i),
             32'({a_state, a_maxL, a_maxH, a_err, a_EN_work, a_EN_set, a_set, a_isWork}),
             32'({tbl[i].st, tbl[i].ml, tbl[i].mh, tbl[i].er, en, en, ~en,
                  (tbl[i].st == 3'd3)}));
      end

      // two-bottle batch on instance A, capacity 03
      drive(1,0,0,0,0,0,0, 4'd0, 4'd0);
      drive(0,0,0,1,0,0,0, 4'd0, 4'd0);
      drive(0,0,0,0,1,0,0, 4'd0, 4'd0);
      drive(0,0,0,0,1,0,0, 4'd0, 4'd0);
      drive(0,0,0,1,0,0,0, 4'd0, 4'd0);
      drive(0,1,0,0,0,0,0, 4'd0, 4'd0);
      chk("batch arm", 32'(a_state), 32'd2);
      idle(4'd0, 4'd0);
      chk("batch fill", 32'({a_state, a_conti, a_isWork}), 32'({3'd3, 1'b0, 1'b1}));
      for (int b = 1; b <= 2; b++) begin
         for (int c = 0; c <= 2; c++) begin
            idle(4'(c), 4'd0);
            chk($sformatf("batch b%0d fill cnt%0d", b, c), 32'({a_state, a_conti}),
                32'({3'd3, 1'b0}));
         end
         idle(4'd3, 4'd0);
         chk($sformatf("batch b%0d swap entry", b), 32'({a_state, a_botH, a_botL}),
             32'({3'd4, 4'd0, 4'(b)}));
         for (int k = 2; k <= 4; k++) begin
            idle(4'd0, 4'd0);
            chk($sformatf("batch b%0d swap cycle %0d", b, k), 32'({a_state, a_conti}),
                32'({3'd4, 1'b0}));
         end
         idle(4'd0, 4'd0);
         if (b == 1) begin
            chk("batch swap exit conti", 32'({a_state, a_conti, a_allFull}),
                32'({3'd3, 1'b1, 1'b0}));
            idle(4'd0, 4'd0);
            chk("batch conti one cycle", 32'({a_state, a_conti}), 32'({3'd3, 1'b0}));
         end else begin
            chk("batch full", 32'({a_state, a_conti, a_allFull, a_isWork}),
                32'({3'd6, 1'b0, 1'b1, 1'b0}));
         end
      end
      drive(0,1,1,0,0,0,0, 4'd3, 4'd0);
      chk("full ignores start", 32'({a_state, a_allFull}), 32'({3'd6, 1'b1}));
      drive(0,0,0,0,0,0,1, 4'd0, 4'd0);
      chk("ack_full", 32'({a_state, a_botH, a_botL, a_allFull, a_EN_work}),
          32'({3'd2, 8'h00, 1'b0, 1'b1}));

      // pause coincident with completion: bottle counted, SWAP, then HOLD
      drive(1,0,0,0,0,0,0, 4'd0, 4'd0);
      drive(0,0,0,1,0,0,0, 4'd0, 4'd0);
      drive(0,0,0,0,1,0,0, 4'd0, 4'd0);
      drive(0,0,0,0,1,0,0, 4'd0, 4'd0);
      drive(0,0,0,1,0,0,0, 4'd0, 4'd0);
      drive(0,1,0,0,0,0,0, 4'd0, 4'd0);
      idle(4'd0, 4'd0);
      drive(0,0,1,0,0,0,0, 4'd3, 4'd0);
      chk("pause+done swap", 32'({a_state, a_botH, a_botL}), 32'({3'd4, 8'h01}));
      for (int k = 2; k <= 4; k++) begin
         idle(4'd0, 4'd0);
         chk($sformatf("pause swap cycle %0d", k), 32'(a_state), 32'd4);
      end
      idle(4'd0, 4'd0);
      chk("pending pause hold", 32'({a_state, a_conti, a_isWork}), 32'({3'd5, 1'b0, 1'b0}));
      drive(0,0,1,0,1,0,1, 4'd3, 4'd0);
      chk("hold ignores inputs", 32'({a_state, a_maxL, a_botL}), 32'({3'd5, 4'd3, 4'd1}));
      drive(0,1,0,0,0,0,0, 4'd0, 4'd0);
      chk("hold resume conti", 32'({a_state, a_conti, a_isWork}), 32'({3'd3, 1'b1, 1'b1}));
      idle(4'd0, 4'd0);
      chk("resume conti one cycle", 32'({a_state, a_conti}), 32'({3'd3, 1'b0}));

      // instance B: ten bottles with BCD carry, then reset mid-SWAP at 07
      drive(1,0,0,0,0,0,0, 4'd0, 4'd0);
      drive(0,0,0,1,0,0,0, 4'd0, 4'd0);
      drive(0,0,0,0,1,0,0, 4'd0, 4'd0);
      drive(0,0,0,1,0,0,0, 4'd0, 4'd0);
      drive(0,1,0,0,0,0,0, 4'd0, 4'd0);
      idle(4'd0, 4'd0);
      for (int b = 1; b <= 10; b++) begin
         idle(4'd2, 4'd0);
         chk($sformatf("B bottle %0d", b), 32'({b_state, b_botH, b_botL}),
             32'({3'd4, 4'(b / 10), 4'(b % 10)}));
         for (int k = 0; k < 3; k++) idle(4'd0, 4'd0);
         idle(4'd0, 4'd0);
         if (b == 10)
            chk("B full at target", 32'({b_state, b_allFull}), 32'({3'd6, 1'b1}));
         else if (b == 9)
            chk("B resume after 9", 32'({b_state, b_allFull, b_conti}), 32'({3'd3, 1'b0, 1'b1}));
      end
      drive(0,0,0,0,0,0,1, 4'd0, 4'd0);
      chk("B ack", 32'({b_state, b_botH, b_botL, b_allFull}), 32'({3'd2, 8'h00, 1'b0}));
      idle(4'd0, 4'd0);
      for (int b = 1; b <= 7; b++) begin
         idle(4'd2, 4'd0);
         if (b < 7) for (int k = 0; k < 4; k++) idle(4'd0, 4'd0);
      end
      idle(4'd0, 4'd0);
      chk("B mid-swap at 07", 32'({b_state, b_botH, b_botL}), 32'({3'd4, 8'h07}));
      drive(1,0,0,0,0,0,0, 4'd2, 4'd0);
      chk("B reset mid-swap",
          32'({b_state, b_botH, b_botL, b_maxL, b_maxH, b_allFull, b_isWork, b_err,
               b_conti, b_EN_work, b_EN_set, b_set}),
          32'({3'd0, 8'h00, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}));

      // randomized stimulus on instance A against the model
      drive(1,0,0,0,0,0,0, 4'd0, 4'd0);
      chk("rand reset", a_vec(), m_vec());
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            cl = 4'(m_maxl); ch = 4'(m_maxh);
         end else begin
            cl = 4'($urandom_range(0, 9)); ch = 4'($urandom_range(0, 9));
         end
         drive(($urandom_range(0, 249) == 0),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), cl, ch);
         chk($sformatf("rand cycle %0d", i), a_vec(), m_vec());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
